// File: rtl/vga_sync_decoder.sv
// Receive-side 640x480 VGA timing recovery: locks to hSync/vSync, recovers pixel
// coordinates and emits an (x, y, rgb) stream with lock and error status.
module vga_sync_decoder #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 659,
  parameter int H_SYNC_END   = 755,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 493
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_error
);

  localparam logic [9:0] HActive = 10'(H_ACTIVE);
  localparam logic [9:0] HTotal  = 10'(H_TOTAL);
  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HSyncSt = 10'(H_SYNC_START);
  localparam logic [9:0] HWidth  = 10'(H_SYNC_END - H_SYNC_START + 1);
  localparam logic [9:0] VActive = 10'(V_ACTIVE);
  localparam logic [9:0] VTotal  = 10'(V_TOTAL);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] VSyncSt = 10'(V_SYNC_START);
  localparam logic [9:0] Sat     = 10'd1023;

  typedef enum logic [1:0] {SEARCH, H_LOCK, LOCKED} state_t;

  state_t      state, stateNext;
  logic        hsR, hsD, vsR, vsD;
  logic [11:0] rgbR;
  logic [9:0]  hcount, vcount, periodCnt, lowCnt, vDist;
  logic        lastPeriodOk, armed;
  logic [1:0]  goodLines;

  logic        hEdge, hRise, vEdge, vEdgeOk, hWrap;
  logic [9:0]  curH, curV, nextH, nextV;
  logic        widthOk, lineOk;
  logic        errHPos, errHMiss, errWidth, errVPos, errVMiss, anyErr;
  logic        syncErrNext, armedNext, lockNext;
  logic [1:0]  goodNext;
  logic [9:0]  vDistNext;

  // Stage-2 decode: curH/curV are the coordinates of the pixel now in stage 1.
  always_comb begin
    hEdge   = hsD & ~hsR;
    hRise   = ~hsD & hsR;
    vEdge   = vsD & ~vsR;
    curH    = hEdge ? HSyncSt : hcount;
    hWrap   = (curH == HLast);
    vEdgeOk = vEdge && (curH == '0);
    curV    = vEdgeOk ? VSyncSt : vcount;
    nextH   = hWrap ? '0 : curH + 10'd1;
    if (hWrap) nextV = (curV == VLast) ? '0 : curV + 10'd1;
    else       nextV = curV;
    widthOk = (lowCnt == HWidth);
    lineOk  = lastPeriodOk && widthOk;
  end

  // Checks against the expected position, not the edge-corrected one.
  always_comb begin
    errHPos  = hEdge && (hcount != HSyncSt);
    errHMiss = (hcount == HSyncSt) && hsR;
    errWidth = hRise && !widthOk;
    errVPos  = vEdge && ((hcount != '0) || (vcount != VSyncSt));
    errVMiss = (hcount == '0) && (vcount == VSyncSt) && vsR;
    anyErr   = errHPos | errHMiss | errWidth | errVPos | errVMiss;
  end

  always_comb begin
    stateNext   = state;
    syncErrNext = 1'b0;
    goodNext    = goodLines;
    armedNext   = armed;
    vDistNext   = (hWrap && (vDist != Sat)) ? vDist + 10'd1 : vDist;
    case (state)
      SEARCH: begin
        armedNext = 1'b0;
        if (hRise) begin
          if (!lineOk) begin
            goodNext = '0;
          end else if (goodLines == 2'd1) begin
            goodNext  = '0;
            stateNext = H_LOCK;
          end else begin
            goodNext = goodLines + 2'd1;
          end
        end
      end
      H_LOCK: begin
        if (hRise && !lineOk) begin
          stateNext = SEARCH;
          armedNext = 1'b0;
          goodNext  = '0;
        end else if (vEdgeOk) begin
          if (armed && (vDist == VTotal)) begin
            stateNext = LOCKED;
          end else begin
            armedNext = 1'b1;
            vDistNext = '0;
          end
        end
      end
      LOCKED: begin
        if (anyErr) begin
          stateNext   = SEARCH;
          syncErrNext = 1'b1;
          armedNext   = 1'b0;
          goodNext    = '0;
        end
      end
      default: stateNext = SEARCH;
    endcase
    lockNext = (stateNext == LOCKED);
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      hsR          <= 1'b1;
      hsD          <= 1'b1;
      vsR          <= 1'b1;
      vsD          <= 1'b1;
      rgbR         <= '0;
      hcount       <= '0;
      vcount       <= '0;
      periodCnt    <= '0;
      lowCnt       <= '0;
      vDist        <= '0;
      lastPeriodOk <= 1'b0;
      armed        <= 1'b0;
      goodLines    <= '0;
      state        <= SEARCH;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_rgb      <= '0;
      pix_valid    <= 1'b0;
      frame_start  <= 1'b0;
      sync_error   <= 1'b0;
    end else begin
      hsD       <= hsR;
      hsR       <= hSync;
      vsD       <= vsR;
      vsR       <= vSync;
      rgbR      <= {red_in, green_in, blue_in};
      hcount    <= nextH;
      vcount    <= nextV;
      periodCnt <= hEdge ? 10'd1 : ((periodCnt == Sat) ? Sat : periodCnt + 10'd1);
      lowCnt    <= hsR ? '0 : ((lowCnt == Sat) ? Sat : lowCnt + 10'd1);
      if (hEdge) lastPeriodOk <= (periodCnt == HTotal);
      vDist       <= vDistNext;
      armed       <= armedNext;
      goodLines   <= goodNext;
      state       <= stateNext;
      pix_x       <= curH;
      pix_y       <= curV;
      pix_rgb     <= rgbR;
      pix_valid   <= lockNext && (curH < HActive) && (curV < VActive);
      frame_start <= lockNext && (curH == '0) && (curV == '0);
      sync_error  <= syncErrNext;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced raster: an ideal generator with
// injected faults, checked against a frame-level lock/pixel prediction.
module tb_vga_sync_decoder;

  localparam int HA  = 16;
  localparam int HT  = 24;
  localparam int HSS = 18;
  localparam int HSE = 20;
  localparam int VA  = 8;
  localparam int VT  = 12;
  localparam int VSS = 9;
  localparam int HW  = HSE - HSS + 1;
  localparam int FR  = HT * VT;

  logic        clk25 = 1'b0;
  logic        rst, hSync, vSync;
  logic [3:0]  red_in, green_in, blue_in;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_rgb;
  logic        pix_valid, frame_start, locked, sync_error;

  always #20 clk25 = ~clk25;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS)
  ) dut (
    .clk25(clk25), .rst(rst), .hSync(hSync), .vSync(vSync),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .frame_start(frame_start), .locked(locked), .sync_error(sync_error)
  );

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        lk;
    logic        er;
  } exp_t;

  exp_t q[$];
  int unsigned passCnt = 0, checkCnt = 0;
  int   gh = 0, gv = 0, pc = 0, mode = 0, faultKind = 0, faultLine = 0, falls = 0, cyc = 0;
  logic prevV = 1'b1, rstLast = 1'b1, genRun = 1'b0, rgbRandom = 1'b0, measure = 1'b0;
  int   fsCyc = -1, beats = 0;
  logic [9:0] lastX = '0, lastY = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCnt++;
    assert (obs === expv) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive the next pixel.
  task automatic tick(input logic r);
    exp_t e;
    logic h, v, hit, er;
    logic [9:0]  hv, vv;
    logic [11:0] px;
    @(posedge clk25);
    #1;
    cyc++;
    if (rstLast) begin
      check("rst_x", pix_x, 0);
      check("rst_y", pix_y, 0);
      check("rst_rgb", pix_rgb, 0);
      check("rst_valid", pix_valid, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_locked", locked, 0);
      check("rst_sync_error", sync_error, 0);
      q.delete();
    end else begin
      if (q.size() == 2) begin
        e = q.pop_front();
        check("rgb", pix_rgb, e.rgb);
        check("locked", locked, e.lk);
        check("sync_error", sync_error, e.er);
        check("valid", pix_valid, e.lk && (e.x < HA) && (e.y < VA));
        check("frame_start", frame_start, e.lk && (e.x == 0) && (e.y == 0));
        if (e.lk) begin
          check("pix_x", pix_x, e.x);
          check("pix_y", pix_y, e.y);
        end
      end
      if (measure) begin
        if (frame_start) begin
          if (fsCyc >= 0) begin
            check("fs_interval", cyc - fsCyc, FR);
            check("frame_beats", beats, HA * VA);
            check("last_x", lastX, HA - 1);
            check("last_y", lastY, VA - 1);
          end
          fsCyc = cyc;
          beats = 0;
        end
        if (pix_valid) begin
          beats++;
          lastX = pix_x;
          lastY = pix_y;
        end
      end
    end

    hv  = 10'(gh);
    vv  = 10'(gv);
    h   = 1'b1;
    v   = 1'b1;
    hit = 1'b0;
    px  = '0;
    if (genRun) begin
      case (mode)
        0: begin
          h = !(gh >= HSS && gh <= HSE);
          v = !(gv == VSS || gv == VSS + 1);
          if (faultKind == 1 && gv == faultLine && gh >= HSS && gh <= HSE) h = 1'b1;
          if (faultKind == 2 && gv == faultLine && gh == HSE) h = 1'b1;
          hit = (faultKind != 0) && (gv == faultLine) && (gh == ((faultKind == 1) ? HSS : HSE));
        end
        1: begin h = 1'b1; v = 1'b1; end
        default: begin h = !(pc < HW); v = 1'b1; end
      endcase
      px = rgbRandom ? 12'($urandom) : {hv[3:0], vv[3:0], hv[7:4]};
    end
    rst   = r;
    hSync = h;
    vSync = v;
    {red_in, green_in, blue_in} = px;

    // Lock is expected from the second vSync fall after reset or after a detected fault.
    if (r) begin
      falls = 0;
      prevV = 1'b1;
    end else begin
      if (prevV && !v) falls++;
      er = hit && (falls >= 2);
      if (er) falls = 0;
      e.x   = hv;
      e.y   = vv;
      e.rgb = px;
      e.lk  = (falls >= 2);
      e.er  = er;
      q.push_back(e);
      prevV = v;
    end
    rstLast = r;

    if (genRun) begin
      pc = (pc == HT) ? 0 : pc + 1;
      if (gh == HT - 1) begin
        gh = 0;
        if (faultKind != 0 && gv == faultLine) faultKind = 0;
        gv = (gv == VT - 1) ? 0 : gv + 1;
      end else begin
        gh++;
      end
    end
  endtask

  initial begin
    int r, hr;
    rst = 1'b1;
    hSync = 1'b1;
    vSync = 1'b1;
    red_in = '0;
    green_in = '0;
    blue_in = '0;

    // Clean start with coordinate-derived colour; frame statistics measured.
    repeat (3) tick(1'b1);
    genRun = 1'b1;
    measure = 1'b1;
    repeat (5 * FR) tick(1'b0);
    measure = 1'b0;
    rgbRandom = 1'b1;

    // Missing hSync pulse on one line.
    faultLine = $urandom_range(1, 5);
    faultKind = 1;
    repeat (3 * FR) tick(1'b0);

    // One hSync pulse one clock short.
    faultLine = $urandom_range(1, 5);
    faultKind = 2;
    repeat (3 * FR) tick(1'b0);

    // Reset mid-frame with hSync high, then relock.
    r  = $urandom_range(1, 5);
    hr = $urandom_range(0, HSS - 2);
    repeat (r * HT + hr) tick(1'b0);
    repeat (3) tick(1'b1);
    repeat (3 * FR - r * HT - hr - 3) tick(1'b0);

    // Syncs idle, then a line period one clock too long: never locks, never errors.
    mode = 1;
    repeat (3) tick(1'b1);
    repeat (2 * FR) tick(1'b0);
    mode = 2;
    pc = 0;
    repeat (3 * FR) tick(1'b0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
